// File: rtl/decode_queue.sv
// decode_queue
//   Multi-lane decode stage with an in-order circular queue between fetch
//   and rename/dispatch. Each cycle up to FETCH_W fetched instructions are
//   decoded in parallel. The group is cut after the first control-flow lane
//   (JAL, predicted-taken branch, JALR) or before the first invalid lane,
//   and the kept lanes are enqueued. Up to DISP_W entries are presented from
//   the queue head every cycle.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   flush             discard queue contents, clear redirect, return to RUN
//   in_valid/inst/pc/order/pred_taken   fetch group, lane 0 is oldest
//   in_ready          group accepted when in_valid[0] && in_ready
//   redirect_valid/pc one-cycle fetch redirect after JAL / taken branch
//   jalr_done         execute has resolved the pending JALR
//   out_*             decoded head entries, lane i = i-th entry from head
//   disp_cnt          number of head entries consumed this cycle
module decode_queue #(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned DISP_W  = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [FETCH_W-1:0]            in_valid,
  input  logic [FETCH_W*32-1:0]         in_inst,
  input  logic [FETCH_W*32-1:0]         in_pc,
  input  logic [FETCH_W*64-1:0]         in_order,
  input  logic [FETCH_W-1:0]            in_pred_taken,
  output logic                          in_ready,
  output logic                          redirect_valid,
  output logic [31:0]                   redirect_pc,
  input  logic                          jalr_done,
  output logic [DISP_W-1:0]             out_valid,
  output logic [DISP_W*32-1:0]          out_pc,
  output logic [DISP_W*32-1:0]          out_inst,
  output logic [DISP_W*32-1:0]          out_imm,
  output logic [DISP_W*32-1:0]          out_next_pc,
  output logic [DISP_W*64-1:0]          out_order,
  output logic [DISP_W*5-1:0]           out_rs1,
  output logic [DISP_W*5-1:0]           out_rs2,
  output logic [DISP_W*5-1:0]           out_rd,
  output logic [DISP_W*2-1:0]           out_rs_type,
  output logic [DISP_W-1:0]             out_reg_write,
  output logic [DISP_W-1:0]             out_pred_taken,
  input  logic [$clog2(DISP_W+1)-1:0]   disp_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [0:0] {RUN, JALR_WAIT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [31:0] next_pc;
    logic [63:0] order;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  rs_type;
    logic        reg_write;
    logic        pred_taken;
  } entry_t;

  function automatic entry_t decode_lane(input logic [31:0] inst,
                                         input logic [31:0] pc,
                                         input logic [63:0] order,
                                         input logic        pred);
    entry_t     e;
    logic [6:0] op;
    logic       lui, auipc, jal, jalr, br, ld, st, opi, opr, known;
    op    = inst[6:0];
    lui   = (op == OP_LUI);
    auipc = (op == OP_AUIPC);
    jal   = (op == OP_JAL);
    jalr  = (op == OP_JALR);
    br    = (op == OP_BRANCH);
    ld    = (op == OP_LOAD);
    st    = (op == OP_STORE);
    opi   = (op == OP_IMM);
    opr   = (op == OP_REG);
    known = lui | auipc | jal | jalr | br | ld | st | opi | opr;

    e.pc    = pc;
    e.inst  = inst;
    e.order = order;
    e.rd    = (st | br | !known) ? '0 : inst[11:7];
    e.rs1   = (lui | auipc | jal | !known) ? '0 : inst[19:15];
    e.rs2   = (opi | ld | jalr | lui | auipc | jal | !known) ? '0 : inst[24:20];

    if (opi | ld | jalr)
      e.imm = {{20{inst[31]}}, inst[31:20]};
    else if (st)
      e.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    else if (br)
      e.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (lui | auipc)
      e.imm = {inst[31:12], 12'b0};
    else if (jal)
      e.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    else
      e.imm = '0;

    e.reg_write  = opr | opi | ld | jalr | lui | auipc | jal;
    if (opr && inst[31:25] == 7'b0000001)
      e.rs_type = 2'b01;
    else if (ld | st)
      e.rs_type = 2'b10;
    else if (br | jalr)
      e.rs_type = 2'b11;
    else
      e.rs_type = 2'b00;
    e.pred_taken = br & pred;
    e.next_pc    = (jal | (br & pred)) ? pc + e.imm : pc + 32'd4;
    return e;
  endfunction

  state_t        state;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  entry_t        mem [DEPTH];

  entry_t             dec [FETCH_W];
  logic [FETCH_W-1:0] lane_redir, lane_jalr;
  logic [CW-1:0]      enq_n, enq_eff;
  logic               end_redir, end_jalr, stop, accept;
  logic [31:0]        redir_tgt;

  always_comb begin
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      dec[i] = decode_lane(in_inst[i*32 +: 32], in_pc[i*32 +: 32],
                           in_order[i*64 +: 64], in_pred_taken[i]);
      lane_redir[i] = (in_inst[i*32 +: 7] == OP_JAL) ||
                      ((in_inst[i*32 +: 7] == OP_BRANCH) && in_pred_taken[i]);
      lane_jalr[i]  = (in_inst[i*32 +: 7] == OP_JALR);
    end
  end

  // Walk lanes oldest-first; the first invalid lane is excluded, the first
  // control-flow lane is kept, and everything younger is dropped.
  always_comb begin
    enq_n     = '0;
    stop      = 1'b0;
    end_redir = 1'b0;
    end_jalr  = 1'b0;
    redir_tgt = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      if (!stop) begin
        if (!in_valid[i]) begin
          stop = 1'b1;
        end else begin
          enq_n = CW'(i + 1);
          if (lane_redir[i]) begin
            stop      = 1'b1;
            end_redir = 1'b1;
            redir_tgt = dec[i].next_pc;
          end else if (lane_jalr[i]) begin
            stop     = 1'b1;
            end_jalr = 1'b1;
          end
        end
      end
    end
  end

  assign in_ready = (state == RUN) && !redirect_valid &&
                    ((DEPTH - 32'(count)) >= FETCH_W);
  assign accept   = in_valid[0] && in_ready && !flush;
  assign enq_eff  = accept ? enq_n : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= RUN;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (flush) begin
      state          <= RUN;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      redirect_valid <= 1'b0;
    end else begin
      head           <= head + PW'(disp_cnt);
      tail           <= tail + PW'(enq_eff);
      count          <= count + enq_eff - CW'(disp_cnt);
      redirect_valid <= accept && end_redir;
      if (accept && end_redir)
        redirect_pc <= redir_tgt;
      case (state)
        RUN:       if (accept && end_jalr) state <= JALR_WAIT;
        JALR_WAIT: if (jalr_done) state <= RUN;
        default:   state <= RUN;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FETCH_W; i++)
      if (i < 32'(enq_eff))
        mem[tail + PW'(i)] <= dec[i];
  end

  always_comb begin
    entry_t e;
    for (int unsigned i = 0; i < DISP_W; i++) begin
      e = mem[head + PW'(i)];
      out_valid[i]          = (32'(count) > i);
      out_pc[i*32 +: 32]    = e.pc;
      out_inst[i*32 +: 32]  = e.inst;
      out_imm[i*32 +: 32]   = e.imm;
      out_next_pc[i*32 +: 32] = e.next_pc;
      out_order[i*64 +: 64] = e.order;
      out_rs1[i*5 +: 5]     = e.rs1;
      out_rs2[i*5 +: 5]     = e.rs2;
      out_rd[i*5 +: 5]      = e.rd;
      out_rs_type[i*2 +: 2] = e.rs_type;
      out_reg_write[i]      = e.reg_write;
      out_pred_taken[i]     = e.pred_taken;
    end
  end

  a_disp_cnt_legal: assert property (@(posedge clk) disable iff (!rst)
    32'(disp_cnt) <= ((32'(count) < DISP_W) ? 32'(count) : DISP_W));

endmodule
